// File: rtl/sram_arbiter_sky130.sv
// Two-requester round-robin arbiter in front of one single-port sky130 SRAM wrapper.
// Grants at most one request per cycle and routes each read's data back to its issuer.
module sram_arbiter_sky130 #(
    parameter int ADDR_WIDTH   = 9,
    parameter int DATA_WIDTH   = 32,
    parameter int WMASK_WIDTH  = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic                   req0_we,
    input  logic [WMASK_WIDTH-1:0] req0_wmask,
    input  logic [ADDR_WIDTH-1:0]  req0_addr,
    input  logic [DATA_WIDTH-1:0]  req0_wdata,
    output logic                   rsp0_valid,
    output logic [DATA_WIDTH-1:0]  rsp0_rdata,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic                   req1_we,
    input  logic [WMASK_WIDTH-1:0] req1_wmask,
    input  logic [ADDR_WIDTH-1:0]  req1_addr,
    input  logic [DATA_WIDTH-1:0]  req1_wdata,
    output logic                   rsp1_valid,
    output logic [DATA_WIDTH-1:0]  rsp1_rdata,
    output logic                   mem_we,
    output logic [WMASK_WIDTH-1:0] mem_wmask,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_din,
    input  logic [DATA_WIDTH-1:0]  mem_dout
);

    typedef struct packed {
        logic vld;
        logic id;
    } rd_tag_t;

    logic    rr_ptr;
    logic    grant0;
    logic    grant1;
    logic    accepted;
    rd_tag_t rd_pipe [READ_LATENCY];
    rd_tag_t rd_last;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (req0_valid && (!req1_valid || !rr_ptr)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accepted   = grant0 | grant1;

    // With no grant the macro sees an idle read of address 0; no response is tracked for it.
    always_comb begin
        mem_we    = 1'b0;
        mem_wmask = '0;
        mem_addr  = '0;
        mem_din   = '0;
        if (grant0) begin
            mem_we    = req0_we;
            mem_wmask = req0_wmask;
            mem_addr  = req0_addr;
            mem_din   = req0_wdata;
        end else if (grant1) begin
            mem_we    = req1_we;
            mem_wmask = req1_wmask;
            mem_addr  = req1_addr;
            mem_din   = req1_wdata;
        end
    end

    // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (accepted) begin
            rr_ptr <= grant0;
        end
    end

    // NOTE: the tag pipeline is a few flops, not a RAM, so every stage is reset to drop in-flight reads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                rd_pipe[i] <= '0;
            end
        end else begin
            rd_pipe[0] <= '{vld: accepted && !mem_we, id: grant1};
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    assign rd_last    = rd_pipe[READ_LATENCY-1];
    assign rsp0_valid = rd_last.vld && !rd_last.id;
    assign rsp1_valid = rd_last.vld && rd_last.id;
    assign rsp0_rdata = mem_dout;
    assign rsp1_rdata = mem_dout;

`ifndef SYNTHESIS
    a_req0_hold: assert property (@(posedge clock) disable iff (reset)
        req0_valid && !req0_ready |=> req0_valid)
        else $error("req0_valid dropped before ready");

    a_req1_hold: assert property (@(posedge clock) disable iff (reset)
        req1_valid && !req1_ready |=> req1_valid)
        else $error("req1_valid dropped before ready");

    a_one_grant: assert property (@(posedge clock) !(req0_ready && req1_ready))
        else $error("both requesters granted in one cycle");
`endif

endmodule

// File: tb/tb_sram_arbiter_sky130.sv
// Scoreboard bench for sram_arbiter_sky130: directed scenarios plus random traffic,
// with a behavioural SRAM wrapper and an address-indexed reference memory.
`timescale 1ns/1ps
module tb_sram_arbiter_sky130;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int RL = 2;

    typedef struct {
        logic          we;
        logic [MW-1:0] wmask;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic          req0_we = 1'b0, req1_we = 1'b0;
    logic [MW-1:0] req0_wmask = '0, req1_wmask = '0;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          mem_we;
    logic [MW-1:0] mem_wmask;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout = '0;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    bit            prio = 1'b0;
    bit            acc0 = 1'b0, acc1 = 1'b0;
    bit            rand_mode = 1'b0;
    logic [DW-1:0] ref_mem [int];
    rsp_t          exp_q [$];
    req_t          q0 [$];
    req_t          q1 [$];
    req_t          cur0, cur1;

    always #5 clock = ~clock;

    sram_arbiter_sky130 #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW), .READ_LATENCY(RL)
    ) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_wmask(req0_wmask), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_wmask(req1_wmask), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Wrapper model: inputs registered on one edge, macro acts on the next.
    logic          w_we = 1'b0;
    logic [MW-1:0] w_mask = '0;
    logic [AW-1:0] w_addr = '0;
    logic [DW-1:0] w_din = '0;
    logic [DW-1:0] sram [0:(1<<AW)-1];

    always @(posedge clock) begin
        w_we   <= mem_we;
        w_mask <= mem_wmask;
        w_addr <= mem_addr;
        w_din  <= mem_din;
        if (w_we) begin
            for (int b = 0; b < MW; b++) begin
                if (w_mask[b]) sram[w_addr][8*b +: 8] <= w_din[8*b +: 8];
            end
        end else begin
            mem_dout <= sram[w_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic req_t mk(input logic we, input logic [MW-1:0] m, input int a, input logic [DW-1:0] d);
        req_t r;
        r.we    = we;
        r.wmask = m;
        r.addr  = AW'(a);
        r.wdata = d;
        return r;
    endfunction

    function automatic req_t rand_req();
        return mk(1'($urandom_range(0, 1)), MW'($urandom), $urandom_range(0, 15), $urandom);
    endfunction

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Request side: expected grant from the round-robin rule, reference memory update, expectation push.
    initial begin : req_mon
        bit            g0, g1;
        req_t          r;
        rsp_t          e;
        logic [DW-1:0] m;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_q.delete();
                prio = 1'b0;
                acc0 = 1'b0;
                acc1 = 1'b0;
                check("reset_outputs", {req0_ready, req1_ready, mem_we, mem_wmask, mem_addr, mem_din}, '0);
            end else begin
                g0 = req0_valid && (!req1_valid || prio == 1'b0);
                g1 = req1_valid && !g0;
                check("req0_ready", 64'(req0_ready), 64'(g0));
                check("req1_ready", 64'(req1_ready), 64'(g1));
                acc0 = req0_valid && req0_ready;
                acc1 = req1_valid && req1_ready;
                if (g0 || g1) begin
                    r = g0 ? cur0 : cur1;
                    check("mem_fields", {mem_we, mem_wmask, mem_addr, mem_din},
                          {r.we, r.wmask, r.addr, r.wdata});
                    if (r.we) begin
                        m = ref_mem.exists(int'(r.addr)) ? ref_mem[int'(r.addr)] : '0;
                        for (int b = 0; b < MW; b++) begin
                            if (r.wmask[b]) m[8*b +: 8] = r.wdata[8*b +: 8];
                        end
                        ref_mem[int'(r.addr)] = m;
                    end else begin
                        e.id   = g1;
                        e.data = ref_mem.exists(int'(r.addr)) ? ref_mem[int'(r.addr)] : '0;
                        e.due  = cyc + RL;
                        exp_q.push_back(e);
                    end
                    prio = g0;
                end else begin
                    check("idle_mem", {mem_we, mem_wmask, mem_addr, mem_din}, '0);
                end
            end
        end
    end

    // Response side: every pulse must match the oldest outstanding read.
    initial begin : rsp_mon
        rsp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                check("reset_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
            end else if (rsp0_valid || rsp1_valid) begin
                check("rsp_onehot", 64'(rsp0_valid && rsp1_valid), 64'(0));
                if (exp_q.size() == 0) begin
                    check("rsp_spurious", {rsp1_valid, rsp0_valid}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", 64'(rsp1_valid), 64'(e.id));
                    check("rsp_cycle", 64'(cyc), 64'(e.due));
                    check("rsp_data", rsp1_valid ? rsp1_rdata : rsp0_rdata, e.data);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                check("rsp_missing", {rsp1_valid, rsp0_valid}, e.id ? 2'b10 : 2'b01);
            end
        end
    end

    // Drivers: hold each request until its handshake, then present the next one.
    initial forever begin
        @(posedge clock);
        #1;
        if (acc0) req0_valid = 1'b0;
        if (!req0_valid) begin
            if (q0.size() > 0) begin
                cur0 = q0.pop_front();
                req0_valid = 1'b1;
            end else if (rand_mode && $urandom_range(0, 9) < 6) begin
                cur0 = rand_req();
                req0_valid = 1'b1;
            end
        end
        if (acc1) req1_valid = 1'b0;
        if (!req1_valid) begin
            if (q1.size() > 0) begin
                cur1 = q1.pop_front();
                req1_valid = 1'b1;
            end else if (rand_mode && $urandom_range(0, 9) < 6) begin
                cur1 = rand_req();
                req1_valid = 1'b1;
            end
        end
        req0_we = cur0.we; req0_wmask = cur0.wmask; req0_addr = cur0.addr; req0_wdata = cur0.wdata;
        req1_we = cur1.we; req1_wmask = cur1.wmask; req1_addr = cur1.addr; req1_wdata = cur1.wdata;
    end

    task automatic drain(input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || req0_valid || req1_valid || exp_q.size() > 0)
               && n < budget) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: traffic still pending after %0d cycles, required idle", budget);
        end
    endtask

    task automatic reset_pulse();
        @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #2 reset = 1'b0;
    endtask

    initial begin
        int n;
        cur0 = mk(1'b0, '0, 0, '0);
        cur1 = mk(1'b0, '0, 0, '0);
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;

        for (int i = 0; i < 16; i++) q0.push_back(mk(1'b1, 4'hF, i, $urandom));
        drain(100);

        // Write then read back through req0.
        q0.push_back(mk(1'b1, 4'hF, 5, 32'hDEADBEEF));
        q0.push_back(mk(1'b0, 4'h0, 5, 32'h0));
        drain(50);

        // Lone req1: back-to-back reads.
        for (int i = 0; i < 4; i++) q1.push_back(mk(1'b0, 4'h0, 10 + i, 32'h0));
        drain(50);

        // Both requesters competing: grants must alternate starting with req0.
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1'b0, 4'h0, 2 * i, 32'h0));
            q1.push_back(mk(1'b0, 4'h0, 2 * i + 1, 32'h0));
        end
        drain(50);

        // Byte-masked write merge: expected read data 0x11BB33DD.
        q0.push_back(mk(1'b1, 4'hF, 9, 32'h11223344));
        q0.push_back(mk(1'b1, 4'b0101, 9, 32'hAABBCCDD));
        q0.push_back(mk(1'b0, 4'h0, 9, 32'h0));
        drain(50);

        // Idle window.
        repeat (10) @(negedge clock);

        // Reset right after a req1 read handshake: the read must vanish.
        q1.push_back(mk(1'b0, 4'h0, 3, 32'h0));
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(req1_valid && req1_ready) && n < 20);
        check("reset_test_handshake", 64'(req1_valid && req1_ready), 64'(1));
        q0.push_back(mk(1'b0, 4'h0, 4, 32'h0));
        q1.push_back(mk(1'b0, 4'h0, 6, 32'h0));
        reset_pulse();
        drain(50);

        // Priority left on req1, then reset: req0 must win the next contest.
        q0.push_back(mk(1'b0, 4'h0, 1, 32'h0));
        drain(50);
        reset_pulse();
        q0.push_back(mk(1'b0, 4'h0, 2, 32'h0));
        q1.push_back(mk(1'b0, 4'h0, 7, 32'h0));
        drain(50);

        // Random traffic over a small address window.
        rand_mode = 1'b1;
        repeat (400) @(negedge clock);
        rand_mode = 1'b0;
        drain(100);
        repeat (5) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion before 200000ns");
        $fatal(1, "timeout");
    end

endmodule
